// File: rtl/mux_scan_nx1.sv
// Registered 2**N_SEL-to-1 multiplexer with manual select and a masked round-robin
// scan that presents each enabled channel for DWELL cycles.
module mux_scan_nx1 #(
    parameter int N_SEL = 2,
    parameter int W     = 8,
    parameter int DWELL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(2**N_SEL)*W-1:0]   in,
    input  logic [N_SEL-1:0]          sel,
    input  logic                      mode,
    input  logic [(2**N_SEL)-1:0]     mask,
    input  logic                      hold,
    output logic [W-1:0]              out,
    output logic [N_SEL-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      wrap
);

    localparam int NCH = 2**N_SEL;
    localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SEL-1:0] cur_q, cur_d;
    logic [CW-1:0]    dwell_q, dwell_d;
    logic [W-1:0]     out_q, out_d;
    logic [N_SEL-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;

    logic [N_SEL-1:0] first_en;
    logic [N_SEL-1:0] next_en;

    function automatic logic [N_SEL-1:0] lowest_enabled(input logic [NCH-1:0] m);
        logic [N_SEL-1:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) res = N_SEL'(i);
        end
        return res;
    endfunction

    // Upward circular search starting after 'from'; lands back on 'from' if it is the only one set.
    function automatic logic [N_SEL-1:0] next_enabled(input logic [N_SEL-1:0] from,
                                                      input logic [NCH-1:0]   m);
        logic [N_SEL-1:0] idx;
        logic [N_SEL-1:0] res;
        logic             found;
        res   = from;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = from + N_SEL'(i);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign first_en = lowest_enabled(mask);
    assign next_en  = next_enabled(cur_q, mask);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        dwell_d     = dwell_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        wrap_d      = 1'b0;

        if (state_q == IDLE) begin
            // Leaving IDLE keeps the outputs at their reset values for this edge.
            if (mode) begin
                state_d = SCAN;
                cur_d   = first_en;
                dwell_d = '0;
            end else begin
                state_d = MANUAL;
            end
        end else if (!mode) begin
            state_d     = MANUAL;
            out_d       = in[int'(sel)*W +: W];
            out_ch_d    = sel;
            out_valid_d = mask[sel];
        end else if (state_q != SCAN) begin
            state_d     = SCAN;
            cur_d       = first_en;
            dwell_d     = '0;
            out_d       = in[int'(first_en)*W +: W];
            out_ch_d    = first_en;
            out_valid_d = mask[first_en];
        end else if (mask == '0) begin
            out_ch_d    = cur_q;
            out_valid_d = 1'b0;
        end else begin
            // A disabled current channel is abandoned at once, ignoring hold and dwell.
            if (!mask[cur_q] || (!hold && dwell_q == DWELL_LAST)) begin
                cur_d   = next_en;
                dwell_d = '0;
                wrap_d  = (next_en <= cur_q);
            end else if (!hold) begin
                dwell_d = dwell_q + CW'(1);
            end
            out_d       = in[int'(cur_d)*W +: W];
            out_ch_d    = cur_d;
            out_valid_d = mask[cur_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            dwell_q     <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            dwell_q     <= dwell_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: directed vector table, then random traffic against a reference model.
module tb_mux_scan_nx1;

    localparam int NCH   = 4;
    localparam int DWELL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_bus;
    logic [1:0]  sel;
    logic        mode;
    logic [3:0]  mask;
    logic        hold;
    logic [7:0]  out;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;

    mux_scan_nx1 #(.N_SEL(2), .W(8), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_bus),
        .sel       (sel),
        .mode      (mode),
        .mask      (mask),
        .hold      (hold),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] mask;
        logic       hold;
        logic [1:0] ch;
        logic       vld;
        logic       wr;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[$];

    // Reference model: phase 0 idle, 1 manual, 2 scan.
    int         m_st, m_cur, m_dw;
    logic [7:0] e_out;
    int         e_ch;
    logic       e_v, e_w;

    function automatic logic [7:0] chan(input int k);
        logic [31:0] sh;
        sh = in_bus >> (8 * k);
        return sh[7:0];
    endfunction

    function automatic int first_on(input logic [3:0] mk);
        for (int k = 0; k < NCH; k++) if (mk[k]) return k;
        return 0;
    endfunction

    function automatic int after(input int c, input logic [3:0] mk);
        for (int k = 1; k <= NCH; k++) if (mk[(c + k) % NCH]) return (c + k) % NCH;
        return c;
    endfunction

    task automatic show(input int k);
        e_out = chan(k);
        e_ch  = k;
        e_v   = mask[k];
    endtask

    task automatic model_edge();
        int nxt;
        if (!rst_n) begin
            m_st = 0; m_cur = 0; m_dw = 0;
            e_out = 8'h00; e_ch = 0; e_v = 1'b0; e_w = 1'b0;
        end else begin
            e_w = 1'b0;
            if (m_st == 0) begin
                m_st = mode ? 2 : 1;
                if (mode) begin
                    m_cur = first_on(mask);
                    m_dw  = 0;
                end
            end else if (!mode) begin
                m_st = 1;
                show(int'(sel));
            end else if (m_st == 1) begin
                m_st  = 2;
                m_cur = first_on(mask);
                m_dw  = 0;
                show(m_cur);
            end else if (mask == 4'h0) begin
                e_ch = m_cur;
                e_v  = 1'b0;
            end else begin
                if (!mask[m_cur] || (!hold && m_dw == DWELL - 1)) begin
                    nxt   = after(m_cur, mask);
                    e_w   = (nxt <= m_cur);
                    m_cur = nxt;
                    m_dw  = 0;
                end else if (!hold) begin
                    m_dw = m_dw + 1;
                end
                show(m_cur);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] mk,
                       input logic h, input logic [1:0] c, input logic v, input logic w,
                       input logic [7:0] d);
        vec_t t;
        t.rst_n = r; t.mode = m; t.sel = s; t.mask = mk; t.hold = h;
        t.ch = c; t.vld = v; t.wr = w; t.dat = d;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; mask = 4'hF; hold = 1'b0;
        in_bus = 32'hD4C3_B2A1;

        //   rst mode sel mask hold | ch vld wrap out
        add(0, 0, 2, 4'hF, 0,   0, 0, 0, 8'h00);  // reset
        add(1, 0, 2, 4'hF, 0,   0, 0, 0, 8'h00);  // IDLE -> MANUAL, outputs still reset
        add(1, 0, 2, 4'hF, 0,   2, 1, 0, 8'hC3);
        add(1, 0, 1, 4'hF, 0,   1, 1, 0, 8'hB2);
        add(1, 0, 2, 4'hB, 0,   2, 0, 0, 8'hC3);
        add(1, 0, 3, 4'hB, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hF, 0,   0, 1, 0, 8'hA1);  // scan entry
        add(1, 1, 0, 4'hF, 0,   0, 1, 0, 8'hA1);
        add(1, 1, 0, 4'hF, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'hF, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'hF, 0,   2, 1, 0, 8'hC3);
        add(1, 1, 0, 4'hF, 0,   2, 1, 0, 8'hC3);
        add(1, 1, 0, 4'hF, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hF, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hF, 0,   0, 1, 1, 8'hA1);  // 3 -> 0 wraps
        add(1, 1, 0, 4'hF, 0,   0, 1, 0, 8'hA1);
        add(1, 1, 0, 4'hA, 0,   1, 1, 0, 8'hB2);  // skip mask 1010
        add(1, 1, 0, 4'hA, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'hA, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hA, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hA, 0,   1, 1, 1, 8'hB2);
        add(1, 1, 0, 4'hA, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'hF, 0,   2, 1, 0, 8'hC3);  // first cycle on ch2
        add(1, 1, 0, 4'hB, 0,   3, 1, 0, 8'hD4);  // ch2 dropped mid-dwell
        add(1, 1, 0, 4'hB, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hB, 0,   0, 1, 1, 8'hA1);
        add(1, 1, 0, 4'h0, 0,   0, 0, 0, 8'hA1);  // mask empty: frozen, invalid
        add(1, 1, 0, 4'h0, 0,   0, 0, 0, 8'hA1);
        add(1, 1, 0, 4'hF, 0,   0, 1, 0, 8'hA1);
        add(1, 1, 0, 4'hF, 0,   1, 1, 0, 8'hB2);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 4'hF, 1, 1, 1, 0, 8'hB2);  // hold on ch1
        add(1, 1, 0, 4'hF, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'hF, 0,   2, 1, 0, 8'hC3);
        add(1, 1, 0, 4'hF, 0,   2, 1, 0, 8'hC3);
        add(1, 1, 0, 4'hF, 0,   3, 1, 0, 8'hD4);
        add(0, 1, 0, 4'hF, 0,   0, 0, 0, 8'h00);  // reset mid-scan
        add(1, 1, 0, 4'hC, 0,   0, 0, 0, 8'h00);  // IDLE -> SCAN, outputs still reset
        add(1, 1, 0, 4'hC, 0,   2, 1, 0, 8'hC3);
        add(1, 1, 0, 4'hC, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hC, 0,   3, 1, 0, 8'hD4);
        add(1, 1, 0, 4'hC, 0,   2, 1, 1, 8'hC3);
        add(1, 1, 0, 4'h2, 0,   1, 1, 1, 8'hB2);  // single enabled channel
        add(1, 1, 0, 4'h2, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'h2, 0,   1, 1, 1, 8'hB2);
        add(1, 1, 0, 4'h2, 0,   1, 1, 0, 8'hB2);
        add(1, 1, 0, 4'h2, 0,   1, 1, 1, 8'hB2);
        add(1, 0, 0, 4'h2, 0,   0, 0, 0, 8'hA1);  // back to manual, ch0 masked

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; mode = vecs[i].mode; sel = vecs[i].sel;
            mask  = vecs[i].mask;  hold = vecs[i].hold;
            tick();
            check($sformatf("vec%0d out", i),       out,             vecs[i].dat);
            check($sformatf("vec%0d out_ch", i),    8'(out_ch),      8'(vecs[i].ch));
            check($sformatf("vec%0d out_valid", i), 8'(out_valid),   8'(vecs[i].vld));
            check($sformatf("vec%0d wrap", i),      8'(wrap),        8'(vecs[i].wr));
        end

        for (int i = 0; i < 3000; i++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
            hold   = ($urandom_range(0, 4) == 0);
            sel    = 2'($urandom_range(0, 3));
            in_bus = $urandom;
            tick();
            check($sformatf("rnd%0d out", i),       out,           e_out);
            check($sformatf("rnd%0d out_ch", i),    8'(out_ch),    8'(e_ch));
            check($sformatf("rnd%0d out_valid", i), 8'(out_valid), 8'(e_v));
            check($sformatf("rnd%0d wrap", i),      8'(wrap),      8'(e_w));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
